// File: rtl/mby_gmm_pkg.sv
// Shared GMM types: pod pointer width, ring slot format and injector FSM states.
package mby_gmm_pkg;

    localparam int unsigned MBY_POD_PTR_W = 16;

    // One slot of the pod pointer ring, shared with GPM.
    typedef struct packed {
        logic                     valid;
        logic [MBY_POD_PTR_W-1:0] pod_ptr;
    } mby_pod_ptr_ring_t;

    typedef enum logic [1:0] {
        POD_INJ_IDLE    = 2'd0,
        POD_INJ_ARMED   = 2'd1,
        POD_INJ_STARVED = 2'd2
    } mby_pod_inj_state_t;

endpackage

// File: rtl/mby_egr_pod_fifo.sv
// Synchronous dirty-pod FIFO; head is presented on dout while non-empty.
module mby_egr_pod_fifo
    import mby_gmm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WIDTH      = MBY_POD_PTR_W
) (
    input  logic                        cclk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // No push while full, even when a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates their use.
    always_ff @(posedge cclk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mby_egr_pod_inject.sv
// Inserts buffered dirty pods into empty, unstalled slots of one pod ring direction.
module mby_egr_pod_inject
    import mby_gmm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned STARVE_THRESH = 64
) (
    input  logic                        cclk,
    input  logic                        reset_n,
    input  logic                        dirty_pod_valid,
    input  logic [MBY_POD_PTR_W-1:0]    dirty_pod_ptr,
    output logic                        dirty_pod_ready,
    input  mby_pod_ptr_ring_t           pod_ring_in,
    output mby_pod_ptr_ring_t           pod_ring_out,
    input  logic                        pod_ring_stall_in,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        inject_pulse,
    output logic                        starved
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BLK_W = $clog2(STARVE_THRESH + 1);

    mby_pod_inj_state_t       state_q, state_d;
    logic [BLK_W-1:0]         blk_q, blk_d;
    logic [MBY_POD_PTR_W-1:0] head;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     inj;
    logic [CW-1:0]            count_after;

    assign push            = dirty_pod_valid && !full;
    assign inj             = !pod_ring_in.valid && !pod_ring_stall_in && !empty;
    assign dirty_pod_ready = !full;
    assign count_after     = fifo_count + CW'(push) - CW'(inj);
    assign starved         = (state_q == POD_INJ_STARVED);

    mby_egr_pod_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (MBY_POD_PTR_W)
    ) u_fifo (
        .cclk    (cclk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (inj),
        .din     (dirty_pod_ptr),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // Next-state and block-counter logic; the counter saturates at STARVE_THRESH.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        case (state_q)
            POD_INJ_IDLE: begin
                blk_d = '0;
                if (push) state_d = POD_INJ_ARMED;
            end
            POD_INJ_ARMED, POD_INJ_STARVED: begin
                if (inj) begin
                    blk_d   = '0;
                    state_d = (count_after == '0) ? POD_INJ_IDLE : POD_INJ_ARMED;
                end else begin
                    if (blk_q != BLK_W'(STARVE_THRESH)) blk_d = blk_q + BLK_W'(1);
                    if (blk_d == BLK_W'(STARVE_THRESH)) state_d = POD_INJ_STARVED;
                end
            end
            default: begin
                state_d = POD_INJ_IDLE;
                blk_d   = '0;
            end
        endcase
    end

    // FSM and block counter state.
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            state_q <= POD_INJ_IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

    // Ring flop: inject the head into a free slot, otherwise forward the upstream slot.
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            pod_ring_out <= '0;
            inject_pulse <= 1'b0;
        end else begin
            inject_pulse <= inj;
            if (inj) begin
                pod_ring_out.valid   <= 1'b1;
                pod_ring_out.pod_ptr <= head;
            end else begin
                pod_ring_out <= pod_ring_in;
            end
        end
    end

endmodule

// File: tb/tb_mby_egr_pod_inject.sv
// Randomized scoreboard bench for mby_egr_pod_inject against a queue-based model.
module tb_mby_egr_pod_inject;
    import mby_gmm_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 4;

    logic                        cclk = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        dirty_pod_valid = 1'b0;
    logic [MBY_POD_PTR_W-1:0]    dirty_pod_ptr = '0;
    logic                        dirty_pod_ready;
    mby_pod_ptr_ring_t           pod_ring_in = '0;
    mby_pod_ptr_ring_t           pod_ring_out;
    logic                        pod_ring_stall_in = 1'b0;
    logic [$clog2(DEPTH):0]      fifo_count;
    logic                        inject_pulse;
    logic                        starved;

    mby_egr_pod_inject #(
        .FIFO_DEPTH    (DEPTH),
        .STARVE_THRESH (THRESH)
    ) dut (
        .cclk              (cclk),
        .reset_n           (reset_n),
        .dirty_pod_valid   (dirty_pod_valid),
        .dirty_pod_ptr     (dirty_pod_ptr),
        .dirty_pod_ready   (dirty_pod_ready),
        .pod_ring_in       (pod_ring_in),
        .pod_ring_out      (pod_ring_out),
        .pod_ring_stall_in (pod_ring_stall_in),
        .fifo_count        (fifo_count),
        .inject_pulse      (inject_pulse),
        .starved           (starved)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        mby_pod_ptr_ring_t ring;
        logic              pulse;
        int                cnt;
        logic              rdy;
        logic              stv;
    } exp_t;

    exp_t                     exp_q[$];
    logic [MBY_POD_PTR_W-1:0] mq[$];
    int                       blocked = 0;
    int                       total = 0;
    int                       bad = 0;
    int                       injections = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Apply one cycle of stimulus and record what the outputs must show after the edge.
    task automatic step(input logic rst, input logic pv, input logic [MBY_POD_PTR_W-1:0] pptr,
                        input logic rv, input logic [MBY_POD_PTR_W-1:0] rptr, input logic st);
        exp_t e;
        int   pre;
        logic do_inj;
        @(negedge cclk);
        reset_n           = !rst;
        dirty_pod_valid   = pv;
        dirty_pod_ptr     = pptr;
        pod_ring_in.valid = rv;
        pod_ring_in.pod_ptr = rptr;
        pod_ring_stall_in = st;
        if (rst) begin
            mq.delete();
            blocked = 0;
            e.ring  = '0;
            e.pulse = 1'b0;
        end else begin
            pre    = mq.size();
            do_inj = !rv && !st && (pre > 0);
            if (do_inj) begin
                e.ring.valid   = 1'b1;
                e.ring.pod_ptr = mq.pop_front();
                injections++;
            end else begin
                e.ring.valid   = rv;
                e.ring.pod_ptr = rptr;
            end
            e.pulse = do_inj;
            if (pv && pre < DEPTH) mq.push_back(pptr);
            if (do_inj || pre == 0) blocked = 0;
            else if (blocked < THRESH) blocked++;
        end
        e.cnt = mq.size();
        e.rdy = (mq.size() < DEPTH);
        e.stv = (blocked >= THRESH);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: compares every registered output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge cclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pod_ring_out", 32'(pod_ring_out), 32'(e.ring));
                chk("inject_pulse", 32'(inject_pulse), 32'(e.pulse));
                chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
                chk("dirty_pod_ready", 32'(dirty_pod_ready), 32'(e.rdy));
                chk("starved", 32'(starved), 32'(e.stv));
            end
        end
    end

    initial begin
        int pv_pct, rv_pct, st_pct;
        // Reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        // Single pod onto an empty ring
        step(1'b0, 1'b1, 16'h002A, 1'b0, '0, 1'b0);
        idle(3);
        // Ring fully occupied with 3 pods queued, then free slots
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'(16'h100 + i), 1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 16'($urandom), 1'b0);
        idle(4);
        // Stall with empty slots and 2 pods queued
        step(1'b0, 1'b1, 16'h0A01, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 16'h0A02, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);
        // Overfill while blocked, push+pop on full, then drain
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b1, 16'(16'h200 + i), 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 16'hCAFE, 1'b1, 16'($urandom), 1'b0);
        idle(DEPTH + 2);
        // Starvation under stall with one pod queued
        step(1'b0, 1'b1, 16'h0555, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        idle(2);
        // Reset with pods queued and valid ring traffic
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h300 + i), 1'b1, 16'($urandom), 1'b0);
        step(1'b1, 1'b1, 16'h0777, 1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 16'($urandom), 1'b0);
        // Randomized traffic with changing densities
        pv_pct = 50; rv_pct = 50; st_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                pv_pct = $urandom_range(100);
                rv_pct = $urandom_range(100);
                st_pct = $urandom_range(60);
            end
            step(($urandom_range(499) == 0),
                 ($urandom_range(99) < pv_pct), 16'($urandom),
                 ($urandom_range(99) < rv_pct), 16'($urandom),
                 ($urandom_range(99) < st_pct));
        end
        idle(DEPTH + 4);
        @(negedge cclk);
        @(negedge cclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("injections_seen", 32'(injections > 20), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mby_egr_pod_inject.md
# mby_egr_pod_inject

Egress-side injector for dirty pod pointers onto one direction of the pod pointer ring. It buffers dirty pods released by egress and inserts them into empty ring slots. It honours the GPM stall, so no new dirty pod enters while GPM asserts stall. Egress instantiates one copy per ring direction (left, right); each copy is the sender paired with GPM's `pod_ring_*_in` / `pod_ring_stall_*_out`.

## Interface
- `FIFO_DEPTH`, 16, dirty-pod buffer entries, power of 2, at least 2.
- `STARVE_THRESH`, 64, consecutive blocked cycles before `starved` asserts, at least 1.
- `cclk`  in  1  core clock; the block's only clock.
- `reset_n`  in  1  reset; synchronous and active-low.
- `dirty_pod_valid`  in  1  egress offers a dirty pod.
- `dirty_pod_ptr`  in  MBY_POD_PTR_W  pod pointer offered.
- `dirty_pod_ready`  out  1  buffer can accept; equals !full.
- `pod_ring_in`  in  mby_pod_ptr_ring_t  upstream ring slot; uses `valid` and `pod_ptr` fields.
- `pod_ring_out`  out  mby_pod_ptr_ring_t  downstream ring slot, registered.
- `pod_ring_stall_in`  in  1  from GPM `pod_ring_stall_*_out`; 1 forbids injection.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `inject_pulse`  out  1  1-cycle pulse, registered, when a pod is injected.
- `starved`  out  1  head blocked for at least STARVE_THRESH cycles.

## Operation
- Push on `dirty_pod_valid && dirty_pod_ready`. There is no push while full, even if a pop happens in the same cycle.
- Injection condition, combinational in cycle t: `inj = !pod_ring_in.valid && !pod_ring_stall_in && !empty`.
  - When `inj` is true: `pod_ring_out` takes `valid=1` and `pod_ptr` = FIFO head, and the head pops.
  - When `inj` is false: `pod_ring_out <= pod_ring_in` unchanged. An occupied slot is never overwritten.
- A valid pass-through slot is forwarded unchanged even while stall is asserted. Stall gates injection only.
- FSM:
  - IDLE: FIFO empty.
  - ARMED: FIFO non-empty and the block counter is below STARVE_THRESH.
  - STARVED: the block counter has reached STARVE_THRESH.
- Block counter:
  - Increments each cycle the FSM is in ARMED or STARVED and `inj`=0.
  - Saturates at STARVE_THRESH.
  - Clears on `inj` or on empty.
- Transitions:
  - IDLE→ARMED on push.
  - ARMED→STARVED when the counter reaches STARVE_THRESH.
  - ARMED/STARVED→ARMED on `inj` with the FIFO non-empty afterwards.
  - ARMED/STARVED→IDLE on `inj` that empties the FIFO.
- `starved` = (state==STARVED), registered.
- FIFO pointers wrap modulo FIFO_DEPTH. The count width holds FIFO_DEPTH.
- Simultaneous push and pop leaves the count unchanged. Data arrives in order.

## Timing
- Ring latency: exactly 1 cycle, whether the slot is passed through or injected.
- A pod pushed in cycle t can be injected in cycle t+1 at the earliest. There is no bypass.
- `fifo_count` and `dirty_pod_ready` reflect the registered state; an update is visible the cycle after the push or pop.
- `inject_pulse` is high in cycle t+1 for an injection in cycle t, aligned with `pod_ring_out`.
- Reset (synchronous, `reset_n`=0 at a cclk edge) sets:
  - `pod_ring_out` = all-zero.
  - `fifo_count`=0, `inject_pulse`=0, `starved`=0.
  - state=IDLE, block counter=0.
  - `dirty_pod_ready`=1 from the first cycle after reset.
- Reset during operation drops buffered pods; pass-through resumes on the first cycle after reset.

## Structure
- `mby_gmm_pkg` holds:
  - `MBY_POD_PTR_W`.
  - `mby_pod_ptr_ring_t`, a shared typedef with GPM.
  - the injector FSM state enum `mby_pod_inj_state_t`.
- Sub-module `mby_egr_pod_fifo`: synchronous FIFO with parameter FIFO_DEPTH. Ports: push, pop, din, dout (head), full, empty, count. The top holds the FSM, the injection mux and the ring flop.

## Test plan
- Empty ring, no stall, push ptr 0x2A at t=0 → `pod_ring_out` valid with ptr 0x2A at t=2; `inject_pulse` high at t=2; count back to 0.
- Ring slots all valid for 10 cycles with 3 pods queued → every slot forwarded bit-exact; no injection; count stays 3; the first free slot carries the oldest pod.
- Stall held for 5 cycles, empty slots, 2 pods queued → no injection during stall; pods injected in the first two cycles after stall drops; FIFO order kept.
- Push FIFO_DEPTH pods while blocked → `dirty_pod_ready`=0 when count=16; push plus pop on a full FIFO accepts nothing; after one pop, ready returns to 1.
- STARVE_THRESH=4, stall held with 1 pod queued → `starved`=1 after 4 blocked cycles; clears the cycle after injection.
- Reset asserted with 5 pods queued and valid ring traffic → next cycle count=0, `pod_ring_out`=0, IDLE; upstream slots pass through from the following cycle.
